// File: rtl/lit_pwl_engine.sv
// lit_pwl_engine: pipelined piecewise-linear inverse tonemapper with a
// double-buffered segment table, valid/ready streaming and bypass.
module lit_pwl_engine #(
  parameter int IN_W      = 9,
  parameter int IN_FRAC   = 8,
  parameter int COEF_W    = 19,
  parameter int COEF_FRAC = 16,
  parameter int OUT_W     = 16,
  parameter int NSEG      = 9,
  parameter int SEG_AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  input  logic              mode_bypass,
  input  logic              cfg_we,
  input  logic [SEG_AW-1:0] cfg_addr,
  input  logic [IN_W-1:0]   cfg_thresh,
  input  logic [COEF_W-1:0] cfg_slope,
  input  logic [COEF_W-1:0] cfg_offset,
  input  logic              cfg_commit
);

  localparam int PW = IN_W + COEF_W;
  localparam int DW = PW + 2;
  localparam int SH = IN_FRAC + COEF_FRAC - OUT_W;
  localparam int BW = IN_W + OUT_W - IN_FRAC;

  localparam logic [COEF_W-1:0] ONE = COEF_W'(1) << COEF_FRAC;
  localparam logic [OUT_W-1:0]  ONES = '1;
  localparam logic signed [DW-1:0] MAXS = DW'((1 << OUT_W) - 1);

  logic [IN_W-1:0]   sh_th_q [NSEG];
  logic [IN_W-1:0]   sh_th_d [NSEG];
  logic [COEF_W-1:0] sh_sl_q [NSEG];
  logic [COEF_W-1:0] sh_sl_d [NSEG];
  logic [COEF_W-1:0] sh_of_q [NSEG];
  logic [COEF_W-1:0] sh_of_d [NSEG];
  logic [IN_W-1:0]   ac_th_q [NSEG];
  logic [COEF_W-1:0] ac_sl_q [NSEG];
  logic [COEF_W-1:0] ac_of_q [NSEG];

  always_comb begin
    sh_th_d = sh_th_q;
    sh_sl_d = sh_sl_q;
    sh_of_d = sh_of_q;
    if (cfg_we && (int'(cfg_addr) < NSEG)) begin
      sh_th_d[cfg_addr] = cfg_thresh;
      sh_sl_d[cfg_addr] = cfg_slope;
      sh_of_d[cfg_addr] = cfg_offset;
    end
  end

  // Commit copies the post-write shadow so a same-cycle write is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        sh_th_q[i] <= '1;
        sh_sl_q[i] <= ONE;
        sh_of_q[i] <= '0;
        ac_th_q[i] <= '1;
        ac_sl_q[i] <= ONE;
        ac_of_q[i] <= '0;
      end
    end else begin
      sh_th_q <= sh_th_d;
      sh_sl_q <= sh_sl_d;
      sh_of_q <= sh_of_d;
      if (cfg_commit) begin
        ac_th_q <= sh_th_d;
        ac_sl_q <= sh_sl_d;
        ac_of_q <= sh_of_d;
      end
    end
  end

  logic [COEF_W-1:0] sel_sl;
  logic [COEF_W-1:0] sel_of;

  always_comb begin
    sel_sl = ac_sl_q[NSEG-1];
    sel_of = ac_of_q[NSEG-1];
    for (int i = NSEG - 2; i >= 0; i--) begin
      if (in_data < ac_th_q[i]) begin
        sel_sl = ac_sl_q[i];
        sel_of = ac_of_q[i];
      end
    end
  end

  logic              adv;
  logic              s1_v_q;
  logic [IN_W-1:0]   s1_px_q;
  logic              s1_byp_q;
  logic [COEF_W-1:0] s1_sl_q;
  logic [COEF_W-1:0] s1_of_q;
  logic              s2_v_q;
  logic [IN_W-1:0]   s2_px_q;
  logic              s2_byp_q;
  logic [PW-1:0]     s2_prod_q;
  logic [COEF_W-1:0] s2_of_q;
  logic              out_v_q;
  logic [OUT_W-1:0]  out_q;
  logic [OUT_W-1:0]  res_d;

  assign adv       = !out_v_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_v_q;
  assign out_data  = out_q;

  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] dsh;
  logic [BW-1:0]        bw;
  logic [OUT_W-1:0]     pwl_res;
  logic [OUT_W-1:0]     byp_res;

  // Offset is pre-scaled so one arithmetic shift drops both fraction gaps.
  always_comb begin
    diff = $signed({2'b00, s2_prod_q}) - $signed(DW'(s2_of_q) << IN_FRAC);
    dsh  = diff >>> SH;
    if (dsh[DW-1]) begin
      pwl_res = '0;
    end else if (dsh > MAXS) begin
      pwl_res = '1;
    end else begin
      pwl_res = dsh[OUT_W-1:0];
    end
    bw      = BW'(s2_px_q) << (OUT_W - IN_FRAC);
    byp_res = (bw > BW'(ONES)) ? ONES : bw[OUT_W-1:0];
    res_d   = s2_byp_q ? byp_res : pwl_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_px_q   <= '0;
      s1_byp_q  <= 1'b0;
      s1_sl_q   <= '0;
      s1_of_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_px_q   <= '0;
      s2_byp_q  <= 1'b0;
      s2_prod_q <= '0;
      s2_of_q   <= '0;
      out_v_q   <= 1'b0;
      out_q     <= '0;
    end else if (adv) begin
      s1_v_q    <= in_valid;
      s1_px_q   <= in_data;
      s1_byp_q  <= mode_bypass;
      s1_sl_q   <= sel_sl;
      s1_of_q   <= sel_of;
      s2_v_q    <= s1_v_q;
      s2_px_q   <= s1_px_q;
      s2_byp_q  <= s1_byp_q;
      s2_prod_q <= PW'(s1_px_q) * PW'(s1_sl_q);
      s2_of_q   <= s1_of_q;
      out_v_q   <= s2_v_q;
      out_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_lit_pwl_engine.sv
// tb_lit_pwl_engine: directed vectors with hand-computed results,
// scoreboarded through a queue of expected outputs.
module tb_lit_pwl_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        mode_bypass;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [8:0]  cfg_thresh;
  logic [18:0] cfg_slope;
  logic [18:0] cfg_offset;
  logic        cfg_commit;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  bit bp_run = 1'b0;

  lit_pwl_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mode_bypass(mode_bypass),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_thresh(cfg_thresh),
    .cfg_slope(cfg_slope), .cfg_offset(cfg_offset),
    .cfg_commit(cfg_commit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic drive_beat(input logic [8:0] d, input logic m);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    mode_bypass = m;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send(input logic [8:0] d, input logic m,
                      input logic [15:0] e);
    exp_q.push_back(e);
    drive_beat(d, m);
  endtask

  task automatic flush(input string tag);
    int k = 0;
    while (got_q.size() < exp_q.size() && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++)
      check($sformatf("%s[%0d]", tag, i), got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [8:0] th,
                           input logic [18:0] sl, input logic [18:0] of);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_thresh = th;
    cfg_slope = sl;
    cfg_offset = of;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    mode_bypass = 1'b0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_thresh = '0;
    cfg_slope = '0;
    cfg_offset = '0;
    cfg_commit = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // three-cycle latency on the identity table
    exp_q.push_back(16'h8000);
    in_valid = 1'b1;
    in_data = 9'h080;
    mode_bypass = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_c1", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_c2", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_c3_valid", out_valid, 1);
    check("lat_c3_data", out_data, 16'h8000);
    send(9'h1FF, 1'b0, 16'hFFFF);
    flush("ident");

    cfg_write(4'd0, 9'h0A4, 19'h05C28, 19'h02E3D);
    commit();
    send(9'h0A0, 1'b0, 16'h0B5C);
    send(9'h000, 1'b0, 16'h0000);
    send(9'h0A4, 1'b0, 16'hA400);
    flush("seg0");

    send(9'h080, 1'b1, 16'h8000);
    send(9'h1FF, 1'b1, 16'hFFFF);
    send(9'h0A0, 1'b0, 16'h0B5C);
    send(9'h0A0, 1'b1, 16'hA000);
    send(9'h000, 1'b0, 16'h0000);
    send(9'h001, 1'b1, 16'h0100);
    flush("bypass");

    bp_run = 1'b1;
    fork
      while (bp_run) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join_none
    send(9'h020, 1'b1, 16'h2000);
    send(9'h02F, 1'b1, 16'h2F00);
    send(9'h03E, 1'b1, 16'h3E00);
    send(9'h04D, 1'b1, 16'h4D00);
    send(9'h0A0, 1'b0, 16'h0B5C);
    send(9'h05C, 1'b1, 16'h5C00);
    send(9'h100, 1'b1, 16'hFFFF);
    send(9'h0C0, 1'b0, 16'hC000);
    send(9'h06B, 1'b1, 16'h6B00);
    send(9'h07A, 1'b1, 16'h7A00);
    send(9'h001, 1'b0, 16'h0000);
    send(9'h089, 1'b1, 16'h8900);
    bp_run = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    flush("backpr");

    // shadow write alone must not disturb the active table
    cfg_write(4'd0, 9'h100, 19'h08000, 19'h00000);
    repeat (4) exp_q.push_back(16'h0B5C);
    exp_q.push_back(16'h5000);
    in_valid = 1'b1;
    in_data = 9'h0A0;
    mode_bypass = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush("commit");

    cfg_write(4'd9, 9'h000, 19'h00000, 19'h7FFFF);
    commit();
    send(9'h0A0, 1'b0, 16'h5000);
    send(9'h1FF, 1'b0, 16'hFFFF);
    flush("badaddr");

    // stall the pipe full, then reset mid-stream
    out_ready = 1'b0;
    drive_beat(9'h0A0, 1'b0);
    drive_beat(9'h0A1, 1'b0);
    drive_beat(9'h0A2, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale", got_q.size(), 0);
    send(9'h0A0, 1'b0, 16'hA000);
    flush("post_rst");

    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_thresh = 9'h1FF;
    cfg_slope = 19'h20000;
    cfg_offset = 19'h00000;
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    send(9'h040, 1'b0, 16'h8000);
    send(9'h1FF, 1'b0, 16'hFFFF);
    flush("wr_commit");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lit_pwl_engine.md
Name: lit_pwl_engine

Overview:
- Parametrised, pipelined piecewise-linear inverse-tonemapping engine. Maps one unsigned pixel code per beat to a linear-light output.
- Segment table holds thresholds, slopes and offsets. It is runtime-programmable and double-buffered, with atomic commit.
- Valid/ready streaming handshake on input and output. Saturating output arithmetic. Bypass mode.
- Sits between the pixel front-end and the linear-domain processing chain. Replaces the fixed 9-segment tonemapper.

Parameters:
- IN_W, 9: input width, unsigned, IN_FRAC fraction bits.
- IN_FRAC, 8: input fraction bits (IN_W-IN_FRAC integer bits).
- COEF_W, 19: slope/offset width, unsigned, COEF_FRAC fraction bits.
- COEF_FRAC, 16: coefficient fraction bits.
- OUT_W, 16: output width, unsigned Q0.OUT_W; OUT_W <= COEF_FRAC.
- NSEG, 9: number of segments, >= 2.
- SEG_AW, 4: segment address width, 2^SEG_AW >= NSEG.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: engine accepts input this cycle.
- in_data, in, IN_W: input pixel code.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts output.
- out_data, out, OUT_W: tonemapped output.
- mode_bypass, in, 1: 1 = bypass, 0 = PWL. Sampled per beat at acceptance.
- cfg_we, in, 1: shadow-table write strobe.
- cfg_addr, in, SEG_AW: segment index; writes with cfg_addr >= NSEG are ignored.
- cfg_thresh, in, IN_W: upper (exclusive) threshold of the segment.
- cfg_slope, in, COEF_W: segment slope.
- cfg_offset, in, COEF_W: segment subtrahend.
- cfg_commit, in, 1: copy shadow table to active table.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, all pipeline valids 0. Both tables reset to thresh=all-ones, slope=1<<COEF_FRAC, offset=0 (identity).
- Segment select: lowest i < NSEG-1 with in_data < thresh[i]; if none, segment NSEG-1. thresh[NSEG-1] is stored but ignored.
- Pipeline, fixed latency 3 cycles from acceptance to out_valid.
  - S1: register in_data, mode_bypass, selected slope and offset from the active table. Coefficients travel with the beat.
  - S2: prod = in_data*slope (IN_W+COEF_W bits), then shifted right by IN_FRAC giving Q.COEF_FRAC.
  - S3: diff = prod_s - offset in signed (IN_W+COEF_W-IN_FRAC+2) bits. Then shift right by (COEF_FRAC-OUT_W), truncating. Then saturate: negative -> 0; >= 2^OUT_W -> all-ones.
- Bypass result: min(in_data << (OUT_W-IN_FRAC), all-ones), also saturating. Same 3-cycle latency.
- Handshake:
  - Global stall: in_ready = !out_valid | out_ready.
  - When stalled, all stages hold and data is never dropped or duplicated.
  - Bubbles propagate and do not compress.
  - in_ready has no combinational dependency on in_valid.
  - Full throughput is 1 beat/cycle.
- Config:
  - cfg_we writes the shadow entry on the clock edge.
  - cfg_commit copies the entire shadow table to the active table on the edge. A write and commit in the same cycle commits the newly written value.
  - Beats accepted on the commit edge use the old table. Beats accepted from the next cycle use the new table. In-flight beats are unaffected.
- Mid-stream reset clears all valids immediately. Partial beats are discarded, and the tables return to identity.

Test Plan:
- Reset then stream in_data=0x080 in PWL mode -> out_data=0x8000 after 3 cycles; in_data=0x1FF -> 0xFFFF (saturated).
- Write seg0 {thresh=0x0A4, slope=0x05C28, offset=0x02E3D}, commit, send 0x0A0 -> 0x0B5C; send 0x000 -> 0x0000 (negative clamp); send 0x0A4 -> segment 1 identity -> 0xA400.
- mode_bypass=1, in_data=0x080 -> 0x8000; in_data=0x1FF -> 0xFFFF; alternate mode per beat -> each output follows its own beat's mode.
- Back-to-back beats with out_ready toggled in a random pattern -> in-order outputs, no loss or duplication, in_ready=0 exactly when out_valid=1 and out_ready=0.
- Commit while 3 beats are in flight and issue a 4th beat on the commit edge -> the first 4 outputs use the old table, the next beat uses the new one; a write with cfg_addr=NSEG leaves the table unchanged.
- Assert rst_n low mid-stream for 1 cycle -> out_valid=0 asynchronously, no stale beat emerges, table back to identity.
